uart_tx_framer: RTL

//  - UART transmit framer: accepts one parallel byte and emits a serial frame on TX_OUT.
//  - Frame order: start(0), 8 data bits, optional parity, stop(1).
//  - Data bits go MSB first (P_DATA[7] first), so the peer deserializer, which shifts left, rebuilds the byte.
//  - Runs on the oversampled system clock; each bit is held for Prescale clk cycles.
//  - Sits between the TX FIFO / system controller and the UART pad.

---
 rtl/uart_tx_framer_if.sv | 40 ++++
 rtl/uart_tx_framer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer_if.sv
// Handshake bundle between the TX FIFO/controller and the UART TX framer.
// Parity lines exist only when UART_TX_PARITY_EN is defined.
interface uart_tx_framer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRE_WIDTH  = 6
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic [PRE_WIDTH-1:0]  Prescale;
`ifdef UART_TX_PARITY_EN
  logic                  PAR_EN;
  logic                  PAR_TYP;
`endif
  logic                  TX_OUT;
  logic                  busy;

  modport master (
`ifdef UART_TX_PARITY_EN
    output PAR_EN,
    output PAR_TYP,
`endif
    output P_DATA,
    output DATA_VALID,
    output Prescale,
    input  TX_OUT,
    input  busy
  );

  modport slave (
`ifdef UART_TX_PARITY_EN
    input  PAR_EN,
    input  PAR_TYP,
`endif
    input  P_DATA,
    input  DATA_VALID,
    input  Prescale,
    output TX_OUT,
    output busy
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART TX framer: start, MSB-first data, optional parity, stop.
// Optional parity slot enabled by defining UART_TX_PARITY_EN.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRE_WIDTH  = 6
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_framer_if.slave  bus
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] w_shreg_nxt;
  logic [BW-1:0]         r_bit_cnt;
  logic [BW-1:0]         w_bit_nxt;
  logic [PRE_WIDTH-1:0]  r_edge_cnt;
  logic [PRE_WIDTH-1:0]  w_edge_nxt;
  logic [PRE_WIDTH-1:0]  r_plast;
  logic [PRE_WIDTH-1:0]  w_plast_nxt;
  logic [PRE_WIDTH-1:0]  w_plast_in;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  w_edge_last;
`ifdef UART_TX_PARITY_EN
  logic                  r_par_en;
  logic                  w_par_en_nxt;
  logic                  r_par;
  logic                  w_par_nxt;
  logic                  w_par_in;
`endif

  // Prescale 0 behaves as 1, so the last edge index is stored directly.
  assign w_plast_in  = (bus.Prescale == '0) ? '0
                     : bus.Prescale - 1'b1;
  assign w_edge_last = (r_edge_cnt == r_plast);
`ifdef UART_TX_PARITY_EN
  assign w_par_in = bus.PAR_TYP ? ~^bus.P_DATA
                                :  ^bus.P_DATA;
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit_cnt;
    w_edge_nxt  = w_edge_last ? '0 : r_edge_cnt + 1'b1;
    w_plast_nxt = r_plast;
    w_tx_nxt    = 1'b1;
    w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_par_en_nxt = r_par_en;
    w_par_nxt    = r_par;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_edge_nxt = '0;
        w_bit_nxt  = '0;
        w_busy_nxt = 1'b0;
        if (bus.DATA_VALID) begin
          w_state_nxt = S_START;
          w_shreg_nxt = bus.P_DATA;
          w_plast_nxt = w_plast_in;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_par_en_nxt = bus.PAR_EN;
          w_par_nxt    = w_par_in;
`endif
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_edge_last) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shreg[MSB];
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shreg[MSB];
        if (w_edge_last) begin
          if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_bit_nxt   = r_bit_cnt + 1'b1;
            w_shreg_nxt = r_shreg << 1;
            w_tx_nxt    = r_shreg[MSB-1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx_nxt = r_par;
        if (w_edge_last) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_edge_last) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered line outputs; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_edge_cnt <= '0;
      r_plast    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_plast    <= w_plast_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= w_par_en_nxt;
      r_par      <= w_par_nxt;
`endif
    end
  end

  assign bus.TX_OUT = r_tx;
  assign bus.busy   = r_busy;
endmodule
